// File: rtl/ddr_reset_sequencer_pkg.sv
// Shared state encoding and default timing for the DDR reset sequencer.
package ddr_package;

    typedef enum logic [2:0] {
        IDLE,
        PWR,
        RST_LO,
        CKE_WAIT,
        XPR_WAIT,
        READY
    } rst_state_e;

    localparam int DEF_CHANNELS    = 1;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_T_PWR       = 10;
    localparam int DEF_T_RESET     = 20;
    localparam int DEF_T_RST_CKE   = 50;
    localparam int DEF_T_XPR       = 30;
    localparam int DEF_WDOG_CYCLES = 1000;

    // A programmed duration of 0 still occupies the state for one cycle.
    function automatic int eff_cycles(input int t);
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/ddr_rst_chan_fsm.sv
// One DDR channel's power-up sequence: IDLE -> PWR -> RST_LO -> CKE_WAIT -> XPR_WAIT -> READY.
module ddr_rst_chan_fsm
    import ddr_package::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int T_PWR     = DEF_T_PWR,
    parameter int T_RESET   = DEF_T_RESET,
    parameter int T_RST_CKE = DEF_T_RST_CKE,
    parameter int T_XPR     = DEF_T_XPR
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       restart_req,
    output logic       restart_ack,
    output logic       reset_n,
    output logic       cke,
    output logic       init_done,
    output rst_state_e state
);

    localparam logic [CNT_W-1:0] LIM_PWR     = CNT_W'(eff_cycles(T_PWR) - 1);
    localparam logic [CNT_W-1:0] LIM_RESET   = CNT_W'(eff_cycles(T_RESET) - 1);
    localparam logic [CNT_W-1:0] LIM_RST_CKE = CNT_W'(eff_cycles(T_RST_CKE) - 1);
    localparam logic [CNT_W-1:0] LIM_XPR     = CNT_W'(eff_cycles(T_XPR) - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    rst_state_e       next;
    logic             accept;

    always_comb begin
        limit = '0;
        case (state)
            PWR:      limit = LIM_PWR;
            RST_LO:   limit = LIM_RESET;
            CKE_WAIT: limit = LIM_RST_CKE;
            XPR_WAIT: limit = LIM_XPR;
            default:  limit = '0;
        endcase
    end

    always_comb begin
        next   = state;
        accept = 1'b0;
        case (state)
            IDLE:     if (start)        next = PWR;
            PWR:      if (cnt == limit) next = RST_LO;
            RST_LO:   if (cnt == limit) next = CKE_WAIT;
            CKE_WAIT: if (cnt == limit) next = XPR_WAIT;
            XPR_WAIT: if (cnt == limit) next = READY;
            READY: begin
                if (restart_req) begin
                    next   = RST_LO;
                    accept = 1'b1;
                end
            end
            default:  next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the entering edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            restart_ack <= 1'b0;
            reset_n     <= 1'b1;
            cke         <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state       <= next;
            if (next != state || state == IDLE || state == READY)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            restart_ack <= accept;
            reset_n     <= (next != RST_LO);
            cke         <= (next == XPR_WAIT) || (next == READY);
            init_done   <= (next == READY);
        end
    end

endmodule

// File: rtl/ddr_reset_sequencer.sv
// Multi-channel DDR reset/CKE sequencer; define DDR_RST_WDOG_EN to add the init watchdog.
module ddr_reset_sequencer
    import ddr_package::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int T_PWR       = DEF_T_PWR,
    parameter int T_RESET     = DEF_T_RESET,
    parameter int T_RST_CKE   = DEF_T_RST_CKE,
    parameter int T_XPR       = DEF_T_XPR,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CHANNELS-1:0] restart_req,
    output logic [CHANNELS-1:0] restart_ack,
    output logic [CHANNELS-1:0] reset_n,
    output logic [CHANNELS-1:0] cke,
    output logic [CHANNELS-1:0] init_done,
    output logic                all_done,
    output logic                busy,
    output logic                init_err
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("CHANNELS must be within 1..8");
    end
    if (64'(T_PWR) >= CNT_SPAN || 64'(T_RESET) >= CNT_SPAN ||
        64'(T_RST_CKE) >= CNT_SPAN || 64'(T_XPR) >= CNT_SPAN) begin : g_bad_timing
        $error("timing parameter does not fit in CNT_W bits");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    rst_state_e chan_state [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ddr_rst_chan_fsm #(
            .CNT_W     (CNT_W),
            .T_PWR     (T_PWR),
            .T_RESET   (T_RESET),
            .T_RST_CKE (T_RST_CKE),
            .T_XPR     (T_XPR)
        ) u_fsm (
            .clock       (clock),
            .reset       (reset),
            .start       (start),
            .restart_req (restart_req[i]),
            .restart_ack (restart_ack[i]),
            .reset_n     (reset_n[i]),
            .cke         (cke[i]),
            .init_done   (init_done[i]),
            .state       (chan_state[i])
        );
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan_state[i] != IDLE && chan_state[i] != READY)
                busy = 1'b1;
        end
    end

    assign all_done = &init_done;

`ifdef DDR_RST_WDOG_EN
    localparam logic [31:0] WD_MAX = 32'(WDOG_CYCLES);

    logic        wd_run;
    logic        wd_run_next;
    logic [31:0] wd_cnt;
    logic [31:0] wd_next;

    // All channels leave IDLE together, so channel 0 marks the start of sequencing.
    always_comb begin
        wd_run_next = wd_run;
        wd_next     = wd_cnt;
        if (!wd_run && start && chan_state[0] == IDLE) begin
            wd_run_next = 1'b1;
            wd_next     = '0;
        end else if (wd_run) begin
            if (|restart_ack)
                wd_next = 32'd1;
            else if (wd_cnt != WD_MAX)
                wd_next = wd_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_run   <= 1'b0;
            wd_cnt   <= '0;
            init_err <= 1'b0;
        end else begin
            wd_run <= wd_run_next;
            wd_cnt <= wd_next;
            if (wd_run_next && wd_next == WD_MAX && !all_done)
                init_err <= 1'b1;
        end
    end
`else
    assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_reset_sequencer.sv
// Directed bench: 4-channel sequencer with default timing plus a short-timing single channel.
module tb_ddr_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] req   = '0;
    logic [3:0] ack_a, reset_n_a, cke_a, done_a;
    logic       all_a, busy_a, err_a;

    logic [0:0] req_b = '0;
    logic [0:0] ack_b, reset_n_b, cke_b, done_b;
    logic       all_b, busy_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DDR_RST_WDOG_EN
    localparam int EXP_ERR_EDGE = 50;
    localparam int EXP_ERR_END  = 1;
`else
    localparam int EXP_ERR_EDGE = -1;
    localparam int EXP_ERR_END  = 0;
`endif

    always #5 clock = ~clock;

    ddr_reset_sequencer #(
        .CHANNELS    (4),
        .WDOG_CYCLES (50)
    ) u_a (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .restart_req (req),
        .restart_ack (ack_a),
        .reset_n     (reset_n_a),
        .cke         (cke_a),
        .init_done   (done_a),
        .all_done    (all_a),
        .busy        (busy_a),
        .init_err    (err_a)
    );

    ddr_reset_sequencer #(
        .CHANNELS  (1),
        .T_PWR     (2),
        .T_RESET   (0),
        .T_RST_CKE (3),
        .T_XPR     (2)
    ) u_b (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .restart_req (req_b),
        .restart_ack (ack_b),
        .reset_n     (reset_n_b),
        .cke         (cke_b),
        .init_done   (done_b),
        .all_done    (all_b),
        .busy        (busy_b),
        .init_err    (err_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int a_fall = -1, a_rise = -1, a_low = 0, a_cke = -1, a_done = -1, a_all = -1;
        int c1_done = -1, err_edge = -1, ack_seen = 0;
        int b_fall = -1, b_low = 0, b_cke = -1, b_done = -1;
        int r_rise = -1, r_done = -1, r_low = 0, others_ok = 1, ack_extra = 0;

        repeat (2) step();
        check("rst_reset_n", int'(reset_n_a), 15);
        check("rst_cke", int'(cke_a), 0);
        check("rst_init_done", int'(done_a), 0);
        check("rst_all_done", int'(all_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_ack", int'(ack_a), 0);
        check("rst_init_err", int'(err_a), 0);

        #2 reset = 1'b0;
        repeat (3) step();
        check("idle_busy", int'(busy_a), 0);

        start = 1'b1;
        step();
        check("start_busy", int'(busy_a), 1);
        check("start_reset_n", int'(reset_n_a), 15);
        check("start_cke", int'(cke_a), 0);

        for (int e = 1; e < 120; e++) begin
            if (e == 5)  start = 1'b0;
            if (e == 40) req = 4'b0010;
            step();
            req = '0;
            if (a_fall < 0 && !reset_n_a[0]) a_fall = e;
            if (a_fall >= 0 && a_rise < 0 && reset_n_a[0]) a_rise = e;
            if (!reset_n_a[0]) a_low++;
            if (a_cke < 0 && cke_a[0]) a_cke = e;
            if (a_done < 0 && done_a[0]) a_done = e;
            if (a_all < 0 && all_a) a_all = e;
            if (c1_done < 0 && done_a[1]) c1_done = e;
            if (err_edge < 0 && err_a) err_edge = e;
            if (ack_a != 4'b0000) ack_seen = 1;
            if (b_fall < 0 && !reset_n_b[0]) b_fall = e;
            if (!reset_n_b[0]) b_low++;
            if (b_cke < 0 && cke_b[0]) b_cke = e;
            if (b_done < 0 && done_b[0]) b_done = e;
        end
        check("ch0_reset_n_fall", a_fall, 10);
        check("ch0_reset_n_rise", a_rise, 30);
        check("ch0_reset_n_low_cycles", a_low, 20);
        check("ch0_cke_rise", a_cke, 80);
        check("ch0_init_done_rise", a_done, 110);
        check("all_done_rise", a_all, 110);
        check("ch1_done_after_ignored_req", c1_done, 110);
        check("no_ack_outside_ready", ack_seen, 0);
        check("ready_busy", int'(busy_a), 0);
        check("init_err_edge", err_edge, EXP_ERR_EDGE);
        check("init_err_after_ready", int'(err_a), EXP_ERR_END);
        check("t0_reset_n_fall", b_fall, 2);
        check("t0_rst_lo_cycles", b_low, 1);
        check("t0_cke_rise", b_cke, 6);
        check("t0_init_done_rise", b_done, 8);

        req = 4'b0100;
        step();
        req = '0;
        check("restart_ack", int'(ack_a), 4);
        check("restart_reset_n", int'(reset_n_a), 11);
        check("restart_init_done", int'(done_a), 11);
        check("restart_all_done", int'(all_a), 0);
        check("restart_busy", int'(busy_a), 1);
        for (int r = 1; r <= 105; r++) begin
            step();
            if (!reset_n_a[2]) r_low++;
            if (r_rise < 0 && reset_n_a[2]) r_rise = r;
            if (r_done < 0 && done_a[2]) r_done = r;
            if (!(done_a[0] && done_a[1] && done_a[3])) others_ok = 0;
            if (ack_a != 4'b0000) ack_extra = 1;
        end
        check("ch2_reset_n_rise", r_rise, 20);
        check("ch2_reset_n_low_after_ack", r_low, 19);
        check("ch2_init_done_rise", r_done, 100);
        check("others_stay_ready", others_ok, 1);
        check("ack_single_pulse", ack_extra, 0);

        req = 4'b1111;
        step();
        req = '0;
        check("multi_restart_ack", int'(ack_a), 15);
        check("multi_restart_reset_n", int'(reset_n_a), 0);
        repeat (75) step();
        check("xpr_cke", int'(cke_a), 15);
        check("xpr_init_done", int'(done_a), 0);
        check("xpr_busy", int'(busy_a), 1);

        #2 reset = 1'b1;
        #1;
        check("async_rst_cke", int'(cke_a), 0);
        check("async_rst_busy", int'(busy_a), 0);
        check("async_rst_init_done", int'(done_a), 0);
        check("async_rst_reset_n", int'(reset_n_a), 15);
        #2 reset = 1'b0;
        repeat (20) step();
        check("no_restart_busy", int'(busy_a), 0);
        check("no_restart_reset_n", int'(reset_n_a), 15);
        check("no_restart_init_done", int'(done_a), 0);
        start = 1'b1;
        step();
        check("restart_after_reset_busy", int'(busy_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_reset_sequencer.md
Name: ddr_reset_sequencer

Overview:
- Parametrised power-up/reset sequencer for the DDR4 environment.
- Replaces the fixed-delay reset_n pulse driven from the bench top with an RTL sequence per memory channel: reset_n low, then CKE low wait, then tXPR wait, then ready.
- Supports N channels, programmable cycle counts, and per-channel re-initialisation requests.
- Sits between the clock generator and DDR_TOP/DIMM_MODEL; drives their reset_n/cke and reports init completion to the stimulus block.

Parameters:
- CHANNELS, 1, number of independent memory channels (1..8).
- CNT_W, 16, width of every internal delay counter.
- T_PWR, 10, cycles after start before reset_n is driven low (power-stable phase).
- T_RESET, 20, cycles reset_n held low (tPW_RESET).
- T_RST_CKE, 50, cycles from reset_n rise to CKE rise.
- T_XPR, 30, cycles from CKE rise to init_done.
- WDOG_CYCLES, 1000, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sequencing of all channels begins on the first cycle it is seen high after reset.
- restart_req  in  CHANNELS  per-channel single-cycle pulse requesting re-initialisation.
- restart_ack  out  CHANNELS  one-cycle pulse when a restart_req is accepted.
- reset_n  out  CHANNELS  DDR reset, active low.
- cke  out  CHANNELS  DDR clock enable.
- init_done  out  CHANNELS  high while the channel is in READY.
- all_done  out  1  AND of init_done.
- busy  out  1  OR over channels of (state != IDLE and state != READY).
- init_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset is asynchronous and active-high. During reset:
  - All FSMs go to IDLE and all counters clear.
  - reset_n=all 1, cke=0, init_done=0, all_done=0, busy=0, restart_ack=0, init_err=0.
- Per-channel FSM states and transitions:
  - IDLE -> PWR when start=1. All channels leave IDLE in the same cycle.
  - PWR: reset_n=1, cke=0. Stays T_PWR cycles, then -> RST_LO.
  - RST_LO: reset_n=0, cke=0. Stays T_RESET cycles, then -> CKE_WAIT.
  - CKE_WAIT: reset_n=1, cke=0. Stays T_RST_CKE cycles, then -> XPR_WAIT.
  - XPR_WAIT: reset_n=1, cke=1. Stays T_XPR cycles, then -> READY.
  - READY: reset_n=1, cke=1, init_done=1.
- Counter rules:
  - The counter loads 0 on state entry and increments each cycle.
  - The state exits when count == T_x-1, so a state lasts exactly T_x cycles.
  - A parameter value of 0 is treated as 1.
- Outputs are registered. Each output changes on the clock edge that enters the new state.
- Latency: init_done rises exactly T_PWR+T_RESET+T_RST_CKE+T_XPR cycles after the edge that samples start=1.
- Restart handling:
  - restart_req[i] is honoured only in READY. That channel goes to RST_LO (PWR is skipped), and restart_ack[i]=1 in the same edge.
  - A request seen in any other state is ignored and gets no ack.
  - Other channels are unaffected.
- start is ignored outside IDLE. Deasserting start mid-sequence has no effect.
- Simultaneous restart_req on several READY channels: each is acked and restarted independently in the same cycle.
- If reset is asserted mid-sequence, everything returns to IDLE immediately. A new start is required after reset releases.
- Counters never wrap. The spec requires T_x < 2**CNT_W, checked by an elaboration-time assertion.

Optional Feature:
- Macro: DDR_RST_WDOG_EN.
- Defined:
  - A watchdog counter starts on leaving IDLE and restarts on any restart_ack.
  - If it reaches WDOG_CYCLES while any channel is not READY, init_err is set sticky until reset.
  - The counter saturates at WDOG_CYCLES.
- Undefined: init_err is tied to 0 and no watchdog logic is generated.

Decomposition:
- Package ddr_package: enum rst_state_e {IDLE, PWR, RST_LO, CKE_WAIT, XPR_WAIT, READY} and the default timing constants.
- Sub-module ddr_rst_chan_fsm: one channel's FSM plus its counter. The top instantiates it CHANNELS times with a generate loop and adds the all_done/busy reduction and the watchdog.

Test Plan:
- Defaults, CHANNELS=1, start at cycle 5:
  - reset_n low during cycles 15..34.
  - cke rises at cycle 85.
  - init_done rises at cycle 115; all_done follows at 115.
- CHANNELS=4 with restart_req[2] pulsed 10 cycles after all_done:
  - restart_ack[2] pulses in the same cycle.
  - reset_n[2] low for 20 cycles; init_done[2] back after 100 cycles.
  - Channels 0, 1 and 3 stay READY.
- restart_req[1] pulsed during CKE_WAIT -> no ack; sequence timing unchanged.
- reset asserted during XPR_WAIT -> same cycle cke=0, busy=0, init_done=0; no progress until start is re-applied.
- With DDR_RST_WDOG_EN, WDOG_CYCLES=50 and defaults -> init_err rises 50 cycles after start and stays high after READY. Without the macro, init_err stays 0.
- T_RESET=0 -> RST_LO lasts exactly 1 cycle.
